// File: rtl/xillylite_pkg.sv
// -----------------------------------------------------------------------------
// xillylite_pkg
// Shared constants and helpers for the Xillybus Lite register file.
//   OFS_*            : control-window word offsets, relative to NREGS
//   ID_VALUE_DEFAULT : default constant returned by the ID register
//   strb_mask()      : expands a 4-bit byte strobe into a 32-bit bit mask
// -----------------------------------------------------------------------------
package xillylite_pkg;

    localparam int unsigned OFS_ID         = 0;
    localparam int unsigned OFS_IRQ_STATUS = 1;
    localparam int unsigned OFS_IRQ_ENABLE = 2;
    localparam int unsigned OFS_TIMESTAMP  = 3;

    localparam logic [31:0] ID_VALUE_DEFAULT = 32'h584C_0001;

    // Lane k of the strobe covers bits [8k+7:8k].
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        m = '0;
        for (int k = 0; k < 4; k++) begin
            m[8*k +: 8] = {8{strb[k]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/xillylite_regfile_irq_ctrl.sv
// -----------------------------------------------------------------------------
// xillylite_irq_ctrl
// Interrupt controller for the Lite register file: sticky per-source status
// bits (write-1-to-clear), a read/write enable mask and a registered level
// interrupt output.
//   clk_i, rst_i : clock, synchronous active-high reset
//   evt_i        : per-source one-cycle event pulses
//   sts_wr_i     : write strobe for IRQ_STATUS (W1C)
//   en_wr_i      : write strobe for IRQ_ENABLE
//   wr_bits_i    : write data already masked by the byte strobes
//   wr_mask_i    : byte-strobe bit mask (which enable bits get replaced)
//   status_o     : IRQ_STATUS, zero-extended to 32 bits
//   enable_o     : IRQ_ENABLE, zero-extended to 32 bits
//   irq_o        : registered OR of (status & enable)
// -----------------------------------------------------------------------------
module xillylite_irq_ctrl #(
    parameter int unsigned NIRQ = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NIRQ-1:0] evt_i,
    input  logic            sts_wr_i,
    input  logic            en_wr_i,
    input  logic [NIRQ-1:0] wr_bits_i,
    input  logic [NIRQ-1:0] wr_mask_i,
    output logic [31:0]     status_o,
    output logic [31:0]     enable_o,
    output logic            irq_o
);

    logic [NIRQ-1:0] status_q, status_d;
    logic [NIRQ-1:0] enable_q, enable_d;
    logic            irq_q;

    always_comb begin
        status_d = status_q;
        if (sts_wr_i) begin
            status_d = status_q & ~wr_bits_i;
        end
        // Applied after the clear so a same-cycle event keeps the bit set.
        status_d = status_d | evt_i;

        enable_d = enable_q;
        if (en_wr_i) begin
            enable_d = (enable_q & ~wr_mask_i) | wr_bits_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            status_q <= '0;
            enable_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            status_q <= status_d;
            enable_q <= enable_d;
            // Built from the current registers, so the line follows any
            // status/enable change by exactly one cycle.
            irq_q    <= |(status_q & enable_q);
        end
    end

    assign status_o = 32'(status_q);
    assign enable_o = 32'(enable_q);
    assign irq_o    = irq_q;

endmodule

// File: rtl/xillylite_regfile.sv
// -----------------------------------------------------------------------------
// xillylite_regfile
// Parametrised Xillybus Lite register file: an NREGS-word byte-lane scratch RAM
// followed by a four-word control window (ID, IRQ_STATUS, IRQ_ENABLE,
// TIMESTAMP). Reads have one cycle of latency; unmapped reads return 0.
//   user_clk, user_rst : clock, synchronous active-high reset
//   user_addr          : byte address, word index = user_addr[AW+1:2]
//   user_wren          : write qualifier
//   user_wstrb         : byte-lane enables
//   user_wr_data       : write data
//   user_rden          : read request
//   user_rd_data       : registered read data (holds when no read)
//   user_irq           : level interrupt
//   irq_event          : per-source event pulses
// -----------------------------------------------------------------------------
module xillylite_regfile
    import xillylite_pkg::*;
#(
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NIRQ     = 8,
    parameter logic [31:0] ID_VALUE = ID_VALUE_DEFAULT
) (
    input  logic            user_clk,
    input  logic            user_rst,
    input  logic [31:0]     user_addr,
    input  logic            user_wren,
    input  logic [3:0]      user_wstrb,
    input  logic [31:0]     user_wr_data,
    input  logic            user_rden,
    output logic [31:0]     user_rd_data,
    output logic            user_irq,
    input  logic [NIRQ-1:0] irq_event
);

    // One extra index bit above the RAM range selects the control window.
    localparam int unsigned AW = $clog2(NREGS) + 1;
    localparam int unsigned RW = AW - 1;

    localparam logic [AW-1:0] W_ID  = AW'(NREGS + OFS_ID);
    localparam logic [AW-1:0] W_STS = AW'(NREGS + OFS_IRQ_STATUS);
    localparam logic [AW-1:0] W_EN  = AW'(NREGS + OFS_IRQ_ENABLE);
    localparam logic [AW-1:0] W_TS  = AW'(NREGS + OFS_TIMESTAMP);

    logic [AW-1:0] widx;
    logic          in_ram;
    logic [RW-1:0] ram_idx;
    logic [31:0]   wr_mask;
    logic [31:0]   wr_bits;
    logic          sts_wr;
    logic          en_wr;
    logic [31:0]   ram_rd;
    logic [31:0]   status;
    logic [31:0]   enable;
    logic [31:0]   ts_q;
    logic [31:0]   rd_data_q, rd_data_d;
    logic          unused_bits;

    // ---------------------------------------------------------------- decode
    assign widx    = user_addr[AW+1:2];
    assign in_ram  = ~widx[AW-1];
    assign ram_idx = widx[RW-1:0];

    assign wr_mask = strb_mask(user_wstrb);
    assign wr_bits = user_wr_data & wr_mask;
    assign sts_wr  = user_wren && (widx == W_STS);
    assign en_wr   = user_wren && (widx == W_EN);

    // Address bits outside the word index and irq bits past NIRQ are ignored.
    assign unused_bits = ^{user_addr[31:AW+2], user_addr[1:0], wr_bits, wr_mask};

    // ------------------------------------------------------------ scratch RAM
    // One byte array per lane; no reset so contents survive user_rst. The
    // combinational read sees the pre-edge contents, giving read-before-write.
    for (genvar k = 0; k < 4; k++) begin : g_lane
        logic [7:0] mem [NREGS];

        always_ff @(posedge user_clk) begin
            if (user_wren && user_wstrb[k] && in_ram) begin
                mem[ram_idx] <= user_wr_data[8*k +: 8];
            end
        end

        assign ram_rd[8*k +: 8] = mem[ram_idx];
    end

    // -------------------------------------------------------------- timestamp
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 32'd1;
        end
    end

    // --------------------------------------------------------- irq controller
    xillylite_irq_ctrl #(
        .NIRQ (NIRQ)
    ) u_irq (
        .clk_i     (user_clk),
        .rst_i     (user_rst),
        .evt_i     (irq_event),
        .sts_wr_i  (sts_wr),
        .en_wr_i   (en_wr),
        .wr_bits_i (wr_bits[NIRQ-1:0]),
        .wr_mask_i (wr_mask[NIRQ-1:0]),
        .status_o  (status),
        .enable_o  (enable),
        .irq_o     (user_irq)
    );

    // --------------------------------------------------------------- read mux
    always_comb begin
        rd_data_d = rd_data_q;
        if (user_rden) begin
            if (in_ram) begin
                rd_data_d = ram_rd;
            end else begin
                case (widx)
                    W_ID:    rd_data_d = ID_VALUE;
                    W_STS:   rd_data_d = status;
                    W_EN:    rd_data_d = enable;
                    W_TS:    rd_data_d = ts_q;
                    default: rd_data_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign user_rd_data = rd_data_q;

endmodule

// File: tb/tb_xillylite_regfile.sv
module tb_xillylite_regfile;

    localparam int NR   = 32;
    localparam int NIRQ = 8;
    localparam int W_ID = NR + 0;
    localparam int W_ST = NR + 1;
    localparam int W_EN = NR + 2;
    localparam int W_TS = NR + 3;
    localparam logic [31:0] IDV = 32'h584C_0001;

    logic            user_clk = 1'b0;
    logic            user_rst = 1'b1;
    logic [31:0]     user_addr = '0;
    logic            user_wren = 1'b0;
    logic [3:0]      user_wstrb = '0;
    logic [31:0]     user_wr_data = '0;
    logic            user_rden = 1'b0;
    logic [31:0]     user_rd_data;
    logic            user_irq;
    logic [NIRQ-1:0] irq_event = '0;

    xillylite_regfile #(.NREGS(NR), .NIRQ(NIRQ), .ID_VALUE(IDV)) dut (
        .user_clk     (user_clk),
        .user_rst     (user_rst),
        .user_addr    (user_addr),
        .user_wren    (user_wren),
        .user_wstrb   (user_wstrb),
        .user_wr_data (user_wr_data),
        .user_rden    (user_rden),
        .user_rd_data (user_rd_data),
        .user_irq     (user_irq),
        .irq_event    (irq_event)
    );

    always #5 user_clk = ~user_clk;

    typedef struct {
        logic        wren;
        logic [3:0]  strb;
        int          w;
        logic [31:0] wd;
        logic        rden;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    string       nm_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic        rst_nxt = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
        else n_pass++;
    endtask

    // One bus cycle: drive at negedge, expectation queued at drive time,
    // popped and compared once the registered read data is out.
    task automatic cyc(input logic wren, input logic [3:0] strb, input int w,
                       input logic [31:0] wd, input logic rden, input logic [31:0] exp,
                       input logic [NIRQ-1:0] evt, input string nm);
        @(negedge user_clk);
        user_rst     = rst_nxt;
        user_wren    = wren;
        user_wstrb   = strb;
        user_addr    = 32'(w) << 2;
        user_wr_data = wd;
        user_rden    = rden;
        irq_event    = evt;
        if (rden) begin
            exp_q.push_back(exp);
            nm_q.push_back(nm);
        end
        @(posedge user_clk);
        #1;
        if (rden) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd0, 32'd1);
            end else begin
                check(nm_q.pop_front(), user_rd_data, exp_q.pop_front());
            end
        end
    endtask

    task automatic idle();
        cyc(1'b0, 4'h0, 0, 32'h0, 1'b0, 32'h0, '0, "idle");
    endtask

    task automatic wr(input int w, input logic [31:0] d, input logic [3:0] s, input logic [NIRQ-1:0] evt);
        cyc(1'b1, s, w, d, 1'b0, 32'h0, evt, "wr");
    endtask

    task automatic rd(input int w, input logic [31:0] exp, input string nm);
        cyc(1'b0, 4'h0, w, 32'h0, 1'b1, exp, '0, nm);
    endtask

    task automatic ts_read(output logic [31:0] val);
        @(negedge user_clk);
        user_rst  = 1'b0;
        user_wren = 1'b0;
        user_wstrb = '0;
        user_addr = 32'(W_TS) << 2;
        user_rden = 1'b1;
        irq_event = '0;
        @(posedge user_clk);
        #1;
        val = user_rd_data;
    endtask

    initial begin
        logic [31:0] t0, t1;

        vecs.push_back('{1'b0, 4'h0, W_TS, 32'h0,         1'b1, 32'h0,         "rst_ts"});
        vecs.push_back('{1'b0, 4'h0, W_ST, 32'h0,         1'b1, 32'h0,         "rst_status"});
        vecs.push_back('{1'b0, 4'h0, W_EN, 32'h0,         1'b1, 32'h0,         "rst_enable"});
        vecs.push_back('{1'b1, 4'hF, 5,    32'hDEAD_BEEF, 1'b0, 32'h0,         "wr5_full"});
        vecs.push_back('{1'b1, 4'h1, 5,    32'h0000_0011, 1'b0, 32'h0,         "wr5_lane0"});
        vecs.push_back('{1'b0, 4'h0, 5,    32'h0,         1'b1, 32'hDEAD_BE11, "rd5_merge"});
        vecs.push_back('{1'b0, 4'h0, W_ID, 32'h0,         1'b1, IDV,           "rd_id"});
        vecs.push_back('{1'b1, 4'hF, W_ID, 32'h0,         1'b0, 32'h0,         "wr_id"});
        vecs.push_back('{1'b0, 4'h0, W_ID, 32'h0,         1'b1, IDV,           "rd_id_ro"});
        vecs.push_back('{1'b0, 4'h0, NR+7, 32'h0,         1'b1, 32'h0,         "rd_unmapped7"});
        vecs.push_back('{1'b0, 4'h0, NR+4, 32'h0,         1'b1, 32'h0,         "rd_unmapped4"});
        vecs.push_back('{1'b1, 4'hF, 3,    32'hAAAA_5555, 1'b0, 32'h0,         "wr3_init"});
        vecs.push_back('{1'b1, 4'hF, 3,    32'h1234_5678, 1'b1, 32'hAAAA_5555, "rw3_old"});
        vecs.push_back('{1'b0, 4'h0, 3,    32'h0,         1'b1, 32'h1234_5678, "rd3_new"});
        vecs.push_back('{1'b1, 4'hF, 4,    32'h0,         1'b0, 32'h0,         "wr4_clr"});
        vecs.push_back('{1'b1, 4'h4, 4,    32'hFFFF_FFFF, 1'b0, 32'h0,         "wr4_lane2"});
        vecs.push_back('{1'b0, 4'hF, 4,    32'h1111_1111, 1'b0, 32'h0,         "strb_no_wren"});
        vecs.push_back('{1'b0, 4'h0, 4,    32'h0,         1'b1, 32'h00FF_0000, "rd4_lane2"});
        vecs.push_back('{1'b1, 4'hF, W_EN, 32'hFFFF_FFFF, 1'b0, 32'h0,         "wr_en_all"});
        vecs.push_back('{1'b0, 4'h0, W_EN, 32'h0,         1'b1, 32'h0000_00FF, "rd_en_nirq"});
        vecs.push_back('{1'b1, 4'hF, W_EN, 32'h0,         1'b0, 32'h0,         "wr_en_zero"});
        vecs.push_back('{1'b0, 4'h0, 5,    32'h0,         1'b1, 32'hDEAD_BE11, "rd5_again"});

        // Reset
        repeat (2) @(posedge user_clk);
        #1;
        check("rst_rd_data", user_rd_data, 32'h0);
        check("rst_irq", 32'(user_irq), 32'h0);

        foreach (vecs[i]) begin
            cyc(vecs[i].wren, vecs[i].strb, vecs[i].w, vecs[i].wd, vecs[i].rden,
                vecs[i].exp, '0, vecs[i].nm);
        end
        idle();
        check("rd_hold", user_rd_data, 32'hDEAD_BE11);

        // IRQ: enabled source, set-wins, unstrobed W1C, clean W1C
        wr(W_EN, 32'h4, 4'hF, '0);
        cyc(1'b0, 4'h0, 0, 32'h0, 1'b0, 32'h0, 8'h04, "evt2");
        check("irq_not_yet", 32'(user_irq), 32'h0);
        idle();
        check("irq_assert", 32'(user_irq), 32'h1);
        wr(W_ST, 32'h4, 4'hF, 8'h04);
        check("irq_setwins", 32'(user_irq), 32'h1);
        rd(W_ST, 32'h4, "status_setwins");
        wr(W_ST, 32'h4, 4'hE, '0);
        rd(W_ST, 32'h4, "status_unstrobed");
        wr(W_ST, 32'h4, 4'hF, '0);
        check("irq_clr_lag", 32'(user_irq), 32'h1);
        idle();
        check("irq_deassert", 32'(user_irq), 32'h0);

        // IRQ: disabled source sets status silently, later enable raises irq
        cyc(1'b0, 4'h0, 0, 32'h0, 1'b0, 32'h0, 8'h02, "evt1");
        idle();
        check("irq_masked", 32'(user_irq), 32'h0);
        rd(W_ST, 32'h2, "status_masked");
        wr(W_EN, 32'h6, 4'hF, '0);
        check("irq_en_lag", 32'(user_irq), 32'h0);
        idle();
        check("irq_en_assert", 32'(user_irq), 32'h1);

        // Timestamp delta
        ts_read(t0);
        repeat (6) idle();
        ts_read(t1);
        check("ts_delta", t1 - t0, 32'd7);

        // Timestamp wrap via back-door
        @(negedge user_clk);
        dut.ts_q = 32'hFFFF_FFFD;
        rd(W_TS, 32'hFFFF_FFFE, "ts_fffe");
        rd(W_TS, 32'hFFFF_FFFF, "ts_ffff");
        rd(W_TS, 32'h0000_0000, "ts_wrap");

        // Reset mid-operation with irq pending and a read in the reset cycle
        wr(7, 32'hCAFE_F00D, 4'hF, '0);
        check("irq_pre_rst", 32'(user_irq), 32'h1);
        rst_nxt = 1'b1;
        rd(7, 32'h0, "rd_in_rst");
        rst_nxt = 1'b0;
        check("irq_post_rst", 32'(user_irq), 32'h0);
        rd(W_TS, 32'h0, "ts_post_rst");
        rd(W_ST, 32'h0, "status_post_rst");
        rd(W_EN, 32'h0, "enable_post_rst");
        check("irq_after_rst", 32'(user_irq), 32'h0);
        rd(7, 32'hCAFE_F00D, "ram_kept");

        check("sb_empty", 32'(exp_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/xillylite_regfile.md
Name: xillylite_regfile

Overview:
Parametrised Xillybus Lite register file. It succeeds the fixed 32-word byte-lane scratch array with a configurable-depth scratch RAM and a control window. The control window holds a read-only ID, a free-running timestamp, and an interrupt controller (status/enable) that drives user_irq. It sits in the top level between the vivado_system Lite port (user_*) and fabric event sources.

Parameters:
NREGS, 32, scratch RAM depth in 32-bit words; power of two, 4..1024
NIRQ, 8, number of fabric interrupt sources, 1..32
ID_VALUE, 32'h584C_0001, constant returned by the ID register

Ports:
user_clk  in  1  Lite clock; sole clock of the block
user_rst  in  1  synchronous, active-high reset
user_addr  in  32  byte address; word index w = user_addr[AW+1:2], AW = clog2(NREGS)+1
user_wren  in  1  write qualifier
user_wstrb  in  4  byte-lane enables; lane k covers wr_data[8k+7:8k]
user_wr_data  in  32  write data
user_rden  in  1  read request
user_rd_data  out  32  registered read data
user_irq  out  1  level interrupt to the PS
irq_event  in  NIRQ  per-source one-cycle event pulses, user_clk domain

Behaviour:
- Address map (word index w):
  - 0..NREGS-1: scratch RAM.
  - NREGS+0: ID (RO).
  - NREGS+1: IRQ_STATUS (W1C).
  - NREGS+2: IRQ_ENABLE (RW).
  - NREGS+3: TIMESTAMP (RO).
  - All other indices are unmapped.
- Write rule: a lane is written when user_wren=1 and user_wstrb[k]=1. user_wstrb with user_wren=0 has no effect.
- Unmapped writes and writes to RO registers are ignored.
- IRQ_STATUS/IRQ_ENABLE bits at or above NIRQ read 0 and ignore writes.
- Read latency is 1 cycle. user_rd_data updates on the cycle after user_rden=1 and holds its value otherwise. Unmapped reads return 0.
- Read and write to the same RAM word in the same cycle: the read returns the old contents (read-before-write).
- Reset values:
  - user_rd_data = 0, user_irq = 0, IRQ_STATUS = 0, IRQ_ENABLE = 0, TIMESTAMP = 0.
  - RAM contents are not reset (undefined until written).
- TIMESTAMP:
  - 32-bit counter, +1 every cycle, wraps 32'hFFFF_FFFF -> 0.
  - A read returns the value at the cycle user_rden is sampled.
- IRQ_STATUS[i]:
  - Set when irq_event[i]=1.
  - Cleared when a write to NREGS+1 carries a 1 in bit i with its lane strobed.
  - Simultaneous set and clear: set wins (the bit stays 1).
  - Events set status regardless of the enable bit.
- user_irq = registered OR over (IRQ_STATUS & IRQ_ENABLE). It asserts 1 cycle after the status or enable change that causes it, and deasserts 1 cycle after the clearing write.
- Reset mid-operation: a read issued in the reset cycle returns 0, the pending irq drops next cycle, and RAM is preserved.

Decomposition:
- Package xillylite_pkg holds:
  - word-offset constants OFS_ID=0, OFS_IRQ_STATUS=1, OFS_IRQ_ENABLE=2, OFS_TIMESTAMP=3, all relative to NREGS;
  - the default ID_VALUE;
  - a function computing the byte-strobe merge mask.
- Sub-module xillylite_irq_ctrl (params NIRQ) owns status, enable, W1C logic and the registered user_irq. The top holds the RAM (NREGS x 4 byte-lane arrays), decode, timestamp and the read mux.

Test Plan:
- Reset, then write 32'hDEAD_BEEF with wstrb=4'b1111 to w=5, then write 32'h0000_0011 with wstrb=4'b0001 to w=5, then read w=5 -> user_rd_data=32'hDEAD_BE11 one cycle after rden.
- Read w=NREGS (ID) -> 32'h584C_0001. Write 0 to ID, re-read -> still 32'h584C_0001. Read w=NREGS+7 -> 0.
- Write 32'h1234_5678 to w=3 and read w=3 in the same cycle -> old value returned; next read -> 32'h1234_5678.
- IRQ_ENABLE=32'h0000_0004, pulse irq_event[2] -> user_irq=1 one cycle after status sets. Write W1C 32'h4 in the same cycle as a second irq_event[2] pulse -> bit stays set, irq stays 1. Clean W1C -> user_irq=0 the cycle after.
- Pulse irq_event[1] with its enable=0 -> IRQ_STATUS=32'h2 and user_irq stays 0. Then set enable bit 1 -> user_irq=1 one cycle later.
- Two TIMESTAMP reads N cycles apart -> difference N. Force the counter near 32'hFFFF_FFFE (bench back-door) -> wraps to 0. Assert user_rst for 1 cycle -> counter, status, enable and user_irq read 0.
